// File: rtl/dbg_guv_cmd_seq.sv
// Debug governor command sequencer: decodes AXI-Stream commands into per-channel pause/log
// enables and drop/inject requests, and returns exactly one status word per command.
module dbg_guv_cmd_seq #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned COUNT_W = 16,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        cmd_in_TDATA,
    input  logic               cmd_in_TVALID,
    output logic               cmd_in_TREADY,
    output logic [31:0]        rsp_out_TDATA,
    output logic               rsp_out_TVALID,
    input  logic               rsp_out_TREADY,
    output logic [NUM_CH-1:0]  pause_o,
    output logic [NUM_CH-1:0]  log_en_o,
    output logic               op_req_o,
    output logic               op_kind_o,
    output logic [3:0]         op_ch_o,
    output logic [COUNT_W-1:0] op_count_o,
    input  logic               op_ack_i,
    input  logic               op_done_i,
    output logic               op_abort_o,
    output logic               busy_o
);

    localparam int unsigned TimerW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TimerW-1:0] TimerLast = TimerW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit TimeoutEn = (TIMEOUT != 0);

    localparam logic [3:0] OpNop     = 4'd0;
    localparam logic [3:0] OpPause   = 4'd1;
    localparam logic [3:0] OpUnpause = 4'd2;
    localparam logic [3:0] OpDrop    = 4'd3;
    localparam logic [3:0] OpInject  = 4'd4;
    localparam logic [3:0] OpLog     = 4'd5;
    localparam logic [3:0] OpUnlog   = 4'd6;

    localparam logic [1:0] StatOk      = 2'd0;
    localparam logic [1:0] StatBadOp   = 2'd1;
    localparam logic [1:0] StatBadCh   = 2'd2;
    localparam logic [1:0] StatTimeout = 2'd3;

    typedef enum logic [2:0] {StIdle, StApply, StReq, StWaitDone, StResp} state_e;

    state_e              state_q, state_d;
    logic [31:0]         cmd_q;
    logic [NUM_CH-1:0]   pause_q, log_q;
    logic                op_kind_q;
    logic [3:0]          op_ch_q;
    logic [COUNT_W-1:0]  op_count_q;
    logic [TimerW-1:0]   timer_q;
    logic                abort_q;
    logic [31:0]         rsp_data_q;

    logic [3:0]          cmd_op, cmd_ch;
    logic [COUNT_W-1:0]  cmd_count;
    logic [7:0]          cmd_tag;
    logic                bad_op, bad_ch, go_req, timeout_hit;
    logic [1:0]          apply_stat;
    logic [NUM_CH-1:0]   ch_mask;
    logic                unused_cmd;

    assign cmd_op     = cmd_q[3:0];
    assign cmd_ch     = cmd_q[7:4];
    assign cmd_count  = cmd_q[8 +: COUNT_W];
    assign cmd_tag    = cmd_q[31:24];
    // Count bits above COUNT_W are deliberately ignored.
    assign unused_cmd = ^cmd_q;

    assign bad_op      = cmd_op > OpUnlog;
    assign bad_ch      = 32'(cmd_ch) >= NUM_CH;
    assign go_req      = !bad_op && !bad_ch && (cmd_op == OpDrop || cmd_op == OpInject)
                         && (cmd_count != '0);
    assign timeout_hit = TimeoutEn && (timer_q == TimerLast);
    assign apply_stat  = bad_op ? StatBadOp : (bad_ch ? StatBadCh : StatOk);

    always_comb begin
        ch_mask = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_mask[i] = (cmd_ch == 4'(i));
        end
    end

    function automatic logic [31:0] rsp_word(input logic [3:0] ch, input logic [1:0] st,
                                             input logic [7:0] tag);
        return {18'b0, ch, st, tag};
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (cmd_in_TVALID) state_d = StApply;
            StApply:    state_d = go_req ? StReq : StResp;
            StReq:      if (op_ack_i) state_d = StWaitDone;
            StWaitDone: if (op_done_i || timeout_hit) state_d = StResp;
            StResp:     if (rsp_out_TREADY) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // Outputs decoded from state or driven by registers
    always_comb begin
        cmd_in_TREADY  = (state_q == StIdle);
        busy_o         = (state_q != StIdle);
        op_req_o       = (state_q == StReq);
        rsp_out_TVALID = (state_q == StResp);
        rsp_out_TDATA  = rsp_data_q;
        pause_o        = pause_q;
        log_en_o       = log_q;
        op_kind_o      = op_kind_q;
        op_ch_o        = op_ch_q;
        op_count_o     = op_count_q;
        op_abort_o     = abort_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q      <= '0;
            pause_q    <= '0;
            log_q      <= '0;
            op_kind_q  <= 1'b0;
            op_ch_q    <= '0;
            op_count_q <= '0;
            timer_q    <= '0;
            abort_q    <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            abort_q <= 1'b0;
            if (state_q == StIdle && cmd_in_TVALID) cmd_q <= cmd_in_TDATA;

            if (state_q == StApply) begin
                rsp_data_q <= rsp_word(cmd_ch, apply_stat, cmd_tag);
                if (!bad_op && !bad_ch) begin
                    unique case (cmd_op)
                        OpPause:   pause_q <= pause_q | ch_mask;
                        OpUnpause: pause_q <= pause_q & ~ch_mask;
                        OpLog:     log_q   <= log_q | ch_mask;
                        OpUnlog:   log_q   <= log_q & ~ch_mask;
                        default:   ;
                    endcase
                end
                if (go_req) begin
                    op_kind_q  <= (cmd_op == OpInject);
                    op_ch_q    <= cmd_ch;
                    op_count_q <= cmd_count;
                end
            end

            if (state_q == StReq && op_ack_i) timer_q <= '0;

            if (state_q == StWaitDone) begin
                // A done in the expiry cycle beats the timeout.
                if (op_done_i) begin
                    rsp_data_q <= rsp_word(cmd_ch, StatOk, cmd_tag);
                end else if (timeout_hit) begin
                    rsp_data_q <= rsp_word(cmd_ch, StatTimeout, cmd_tag);
                    abort_q    <= 1'b1;
                end else if (TimeoutEn) begin
                    timer_q <= timer_q + 1'b1;
                end
            end
        end
    end

    // Nop needs no action beyond the OK response.
    logic unused_nop;
    assign unused_nop = (OpNop == 4'd0);

endmodule
